video_meter: RTL and testbench

Sync-measurement stage directly upstream of the scan converter, in the `PCLK_in` domain. It consumes the latched TVP7002 sync signals (`HSYNC_in_L`, `VSYNC_in_L`, `FID_in_L`) and measures the incoming timing:
- pixels per line, lines per field, pixels per field;
- interlace and horizontal-stability flags.

Results feed the `sc_status` / `sc_status2` words read by the CPU, plus the `h_unstable` error LED.

---
 rtl/video_meter_pkg.sv | 30 +++
 rtl/video_meter_sync_edge_det.sv | 33 +++
 rtl/video_meter.sv | 165 ++++++++++++++++
 tb/tb_video_meter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_meter_pkg.sv
// Shared constants for the video_meter sync-measurement stage.
// Holds the default counter widths, the line-stability thresholds and the
// saturation limits used by the counters in video_meter.
package video_meter_pkg;

   localparam int HCNT_W         = 12;
   localparam int VCNT_W         = 11;
   localparam int PCNT_W         = 20;

   localparam int H_TOL          = 2;
   localparam int UNSTABLE_LINES = 4;
   localparam int STABLE_LINES   = 8;

   // Run counters only need to reach the larger of the two thresholds.
   localparam int RUN_W = $clog2(STABLE_LINES + 1);

   typedef logic [HCNT_W-1:0] hcnt_t;
   typedef logic [VCNT_W-1:0] vcnt_t;
   typedef logic [PCNT_W-1:0] pcnt_t;
   typedef logic [RUN_W-1:0]  run_t;

   localparam hcnt_t HCNT_MAX = '1;
   localparam vcnt_t VCNT_MAX = '1;
   localparam pcnt_t PCNT_MAX = '1;

   localparam hcnt_t H_TOL_V        = HCNT_W'(H_TOL);
   localparam run_t  UNSTABLE_RUN   = RUN_W'(UNSTABLE_LINES);
   localparam run_t  STABLE_RUN     = RUN_W'(STABLE_LINES);

endpackage

// File: rtl/video_meter_sync_edge_det.sv
// sync_edge_det: polarity normalisation and leading-edge detection for one
// latched sync input.
// Ports:
//   clk   - pixel clock
//   rst   - asynchronous active-high reset
//   sync  - latched sync input
//   pol   - 1 = sync is active-low
//   level - registered normalised level (1 = active)
//   lead  - high for one cycle on the inactive-to-active transition
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sync,
   input  logic pol,
   output logic level,
   output logic lead
);

   logic s_qq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b0;
         s_qq  <= 1'b0;
      end else begin
         level <= sync ^ pol;
         s_qq  <= level;
      end
   end

   assign lead = level & ~s_qq;

endmodule

// File: rtl/video_meter.sv
// video_meter: measures incoming sync timing in the pixel-clock domain.
// Reports line length, lines and clocks per field, an interlace flag and a
// horizontal-stability flag.
// Ports:
//   PCLK_in    - pixel clock (only clock)
//   reset      - asynchronous active-high reset
//   HSYNC_in   - latched horizontal sync
//   VSYNC_in   - latched vertical sync
//   FID_in     - latched field ID (used only with VIDEO_METER_FID_EN)
//   hsync_pol  - 1 = HSYNC active-low
//   vsync_pol  - 1 = VSYNC active-low
//   h_total    - clocks between the last two HSYNC leading edges
//   vmax       - lines in the last complete field
//   pcnt_frame - clocks in the last complete field
//   ilace_flag - interlaced source detected
//   h_unstable - line length unstable or HSYNC absent
//   vsync_flag - registered, normalised VSYNC level
//   frame_stb  - one-cycle pulse when vmax/pcnt_frame/ilace_flag update
// Build option: define VIDEO_METER_FID_EN to detect interlace from FID
// toggling instead of from the field-length difference.
module video_meter
   import video_meter_pkg::*;
(
   input  logic              PCLK_in,
   input  logic              reset,
   input  logic              HSYNC_in,
   input  logic              VSYNC_in,
   input  logic              FID_in,
   input  logic              hsync_pol,
   input  logic              vsync_pol,
   output logic [HCNT_W-1:0] h_total,
   output logic [VCNT_W-1:0] vmax,
   output logic [PCNT_W-1:0] pcnt_frame,
   output logic              ilace_flag,
   output logic              h_unstable,
   output logic              vsync_flag,
   output logic              frame_stb
);

   logic  h_edge;
   logic  v_edge;
   logic  h_level_unused;

   hcnt_t hcnt;
   vcnt_t vcnt;
   pcnt_t pcnt;
   run_t  mis_ctr;
   run_t  ok_ctr;
   logic  armed;

   hcnt_t h_len;
   hcnt_t h_diff;
   logic  h_match;
   run_t  mis_nxt;
   run_t  ok_nxt;
   pcnt_t pcnt_len;
   vcnt_t vcnt_inc;
   logic  ilace_now;

   sync_edge_det u_hsync (
      .clk   (PCLK_in),
      .rst   (reset),
      .sync  (HSYNC_in),
      .pol   (hsync_pol),
      .level (h_level_unused),
      .lead  (h_edge)
   );

   sync_edge_det u_vsync (
      .clk   (PCLK_in),
      .rst   (reset),
      .sync  (VSYNC_in),
      .pol   (vsync_pol),
      .level (vsync_flag),
      .lead  (v_edge)
   );

   // Length of the line ending now; doubles as the saturating hcnt increment.
   assign h_len    = (hcnt == HCNT_MAX) ? HCNT_MAX : hcnt + 1'b1;
   assign h_diff   = (h_len >= h_total) ? h_len - h_total : h_total - h_len;
   assign h_match  = (h_diff <= H_TOL_V);
   assign mis_nxt  = (mis_ctr == UNSTABLE_RUN) ? mis_ctr : mis_ctr + 1'b1;
   assign ok_nxt   = (ok_ctr == STABLE_RUN) ? ok_ctr : ok_ctr + 1'b1;
   assign pcnt_len = (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + 1'b1;
   assign vcnt_inc = (vcnt == VCNT_MAX) ? VCNT_MAX : vcnt + 1'b1;

`ifdef VIDEO_METER_FID_EN
   logic fid_prev;

   always_ff @(posedge PCLK_in or posedge reset) begin
      if (reset) begin
         fid_prev <= 1'b0;
      end else if (v_edge) begin
         fid_prev <= FID_in;
      end
   end

   assign ilace_now = (FID_in != fid_prev);
`else
   logic fid_unused;

   assign fid_unused = FID_in;
   // Widened by one bit so the +1 cannot wrap at the counter limit.
   assign ilace_now  = ({1'b0, vcnt} == {1'b0, vmax} + 1'b1) ||
                       ({1'b0, vmax} == {1'b0, vcnt} + 1'b1);
`endif

   always_ff @(posedge PCLK_in or posedge reset) begin
      if (reset) begin
         hcnt       <= '0;
         h_total    <= '0;
         mis_ctr    <= '0;
         ok_ctr     <= '0;
         h_unstable <= 1'b0;
      end else begin
         if (h_edge) begin
            hcnt    <= '0;
            h_total <= h_len;
            if (h_match) begin
               mis_ctr <= '0;
               ok_ctr  <= ok_nxt;
               if (ok_nxt == STABLE_RUN) h_unstable <= 1'b0;
            end else begin
               ok_ctr  <= '0;
               mis_ctr <= mis_nxt;
               if (mis_nxt == UNSTABLE_RUN) h_unstable <= 1'b1;
            end
         end else begin
            hcnt <= h_len;
         end
         // A line that never ends is flagged regardless of the run counters.
         if (hcnt == HCNT_MAX) h_unstable <= 1'b1;
      end
   end

   always_ff @(posedge PCLK_in or posedge reset) begin
      if (reset) begin
         vcnt       <= '0;
         pcnt       <= '0;
         armed      <= 1'b0;
         vmax       <= '0;
         pcnt_frame <= '0;
         ilace_flag <= 1'b0;
         frame_stb  <= 1'b0;
      end else begin
         frame_stb <= 1'b0;
         pcnt      <= pcnt_len;
         if (v_edge) begin
            armed <= 1'b1;
            pcnt  <= '0;
            // A coincident H edge opens the first line of the new field.
            vcnt  <= {{(VCNT_W-1){1'b0}}, h_edge};
            if (armed) begin
               vmax       <= vcnt;
               pcnt_frame <= pcnt_len;
               ilace_flag <= ilace_now;
               frame_stb  <= 1'b1;
            end
         end else if (h_edge) begin
            vcnt <= vcnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_video_meter.sv
module tb_video_meter;

   logic        PCLK_in;
   logic        reset;
   logic        HSYNC_in;
   logic        VSYNC_in;
   logic        FID_in;
   logic        hsync_pol;
   logic        vsync_pol;
   logic [11:0] h_total;
   logic [10:0] vmax;
   logic [19:0] pcnt_frame;
   logic        ilace_flag;
   logic        h_unstable;
   logic        vsync_flag;
   logic        frame_stb;

   video_meter dut (
      .PCLK_in    (PCLK_in),
      .reset      (reset),
      .HSYNC_in   (HSYNC_in),
      .VSYNC_in   (VSYNC_in),
      .FID_in     (FID_in),
      .hsync_pol  (hsync_pol),
      .vsync_pol  (vsync_pol),
      .h_total    (h_total),
      .vmax       (vmax),
      .pcnt_frame (pcnt_frame),
      .ilace_flag (ilace_flag),
      .h_unstable (h_unstable),
      .vsync_flag (vsync_flag),
      .frame_stb  (frame_stb)
   );

   initial PCLK_in = 1'b0;
   always #5 PCLK_in = ~PCLK_in;

   localparam int H_MAX = 4095;
   localparam int V_MAX = 2047;
   localparam int P_MAX = 1048575;

   // ---------------- behavioural model (timestamp based) ----------------
   int t, last_h, last_v, lines, mis_run, ok_run;
   bit hp1, hp2, vp1, vp2, armed_m;
   int e_h_total, e_vmax, e_pcnt;
   bit e_ilace, e_unst, e_vsync, e_stb;

   function automatic int iabs(int x);
      return (x < 0) ? -x : x;
   endfunction

   always @(posedge PCLK_in) begin
      int  h_len;
      bit  h_edge, v_edge, sat_now;
      if (reset) begin
         t = 0; last_h = 0; last_v = 0; lines = 0; mis_run = 0; ok_run = 0;
         hp1 = 0; hp2 = 0; vp1 = 0; vp2 = 0; armed_m = 0;
         e_h_total = 0; e_vmax = 0; e_pcnt = 0;
         e_ilace = 0; e_unst = 0; e_vsync = 0; e_stb = 0;
      end else begin
         t++;
         h_edge = hp1 && !hp2;
         v_edge = vp1 && !vp2;
         hp2 = hp1; hp1 = HSYNC_in ^ hsync_pol;
         vp2 = vp1; vp1 = VSYNC_in ^ vsync_pol;
         e_vsync = vp1;
         e_stb   = 0;
         h_len   = t - last_h;
         if (h_len > H_MAX) h_len = H_MAX;
         sat_now = (t - 1 - last_h) >= H_MAX;
         if (h_edge) begin
            if (iabs(h_len - e_h_total) <= 2) begin
               ok_run++; mis_run = 0;
               if (ok_run >= 8) e_unst = 0;
            end else begin
               mis_run++; ok_run = 0;
               if (mis_run >= 4) e_unst = 1;
            end
            e_h_total = h_len;
            last_h    = t;
         end
         if (sat_now) e_unst = 1;
         if (v_edge) begin
            if (armed_m) begin
               e_ilace = (iabs(lines - e_vmax) == 1);
               e_vmax  = lines;
               e_pcnt  = (t - last_v > P_MAX) ? P_MAX : t - last_v;
               e_stb   = 1;
            end
            armed_m = 1;
            last_v  = t;
            lines   = h_edge ? 1 : 0;
         end else if (h_edge && lines < V_MAX) begin
            lines++;
         end
      end
   end

   // ---------------- compare process ----------------
   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } lit_t;
   lit_t lit_q[$];

   int n_vec = 0;
   int n_bad = 0;
   int stb_count = 0;
   int prints = 0;

   function automatic logic [31:0] pick(int sel);
      case (sel)
         0:       return 32'(h_total);
         1:       return 32'(vmax);
         2:       return 32'(pcnt_frame);
         3:       return 32'(ilace_flag);
         4:       return 32'(h_unstable);
         5:       return 32'(vsync_flag);
         6:       return 32'(frame_stb);
         default: return 32'(stb_count);
      endcase
   endfunction

   function automatic bit report(string nm, logic [31:0] act, logic [31:0] exp, bit loud);
      if (act !== exp) begin
         if (loud)
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(negedge PCLK_in) begin
      bit   bad;
      bit   loud;
      lit_t l;
      loud = (prints < 40);
      if (!reset) begin
         bad = 0;
         bad |= report("h_total",    32'(h_total),    32'(e_h_total), loud);
         bad |= report("vmax",       32'(vmax),       32'(e_vmax),    loud);
         bad |= report("pcnt_frame", 32'(pcnt_frame), 32'(e_pcnt),    loud);
         bad |= report("ilace_flag", 32'(ilace_flag), 32'(e_ilace),   loud);
         bad |= report("h_unstable", 32'(h_unstable), 32'(e_unst),    loud);
         bad |= report("vsync_flag", 32'(vsync_flag), 32'(e_vsync),   loud);
         bad |= report("frame_stb",  32'(frame_stb),  32'(e_stb),     loud);
         n_vec++;
         if (bad) begin
            n_bad++;
            prints++;
         end
         if (frame_stb) stb_count++;
      end
      while (lit_q.size() > 0) begin
         l = lit_q.pop_front();
         n_vec++;
         if (report(l.name, pick(l.sel), l.exp, 1'b1)) n_bad++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic expect_lit(int sel, logic [31:0] exp, string name);
      lit_q.push_back('{sel, exp, name});
   endtask

   task automatic step(bit h, bit v);
      HSYNC_in = h ^ hsync_pol;
      VSYNC_in = v ^ vsync_pol;
      @(posedge PCLK_in);
      #1;
   endtask

   // VSYNC is active for two lines starting at clock v_off of line 0.
   task automatic run_field(int nlines, int len, int v_off);
      for (int l = 0; l < nlines; l++)
         for (int c = 0; c < len; c++)
            step(c < 4, (l == 0 && c >= v_off) || (l == 1) || (l == 2 && c < v_off));
   endtask

   task automatic run_lines(int n, int len_a, int len_b);
      for (int l = 0; l < n; l++)
         for (int c = 0; c < ((l % 2 == 0) ? len_a : len_b); c++)
            step(c < 4, 1'b0);
   endtask

   task automatic expect_all_zero(string tag);
      for (int s = 0; s < 7; s++) expect_lit(s, 32'd0, {tag, "_zero"});
   endtask

   initial begin
      int mark;
      reset     = 1'b1;
      hsync_pol = 1'b1;
      vsync_pol = 1'b1;
      FID_in    = 1'b0;
      HSYNC_in  = 1'b1;
      VSYNC_in  = 1'b1;
      repeat (3) @(posedge PCLK_in);
      #1;
      expect_all_zero("por");
      reset = 1'b0;

      // Progressive, active-low syncs: 20-clock lines, 25 lines per field.
      mark = stb_count;
      repeat (3) run_field(25, 20, 7);
      expect_lit(0, 32'd20,  "prog_h_total");
      expect_lit(1, 32'd25,  "prog_vmax");
      expect_lit(2, 32'd500, "prog_pcnt_frame");
      expect_lit(3, 32'd0,   "prog_ilace");
      expect_lit(4, 32'd0,   "prog_h_unstable");
      expect_lit(7, 32'(mark + 2), "prog_stb_count");

      // Interlace: alternating 12/13-line fields.
      run_field(12, 20, 7);
      run_field(13, 20, 7);
      run_field(12, 20, 7);
      run_field(13, 20, 7);
      run_field(12, 20, 7);
      expect_lit(1, 32'd13, "ilace_vmax");
      expect_lit(3, 32'd1,  "ilace_flag");

      // Line jitter outside tolerance, recovery, then jitter inside tolerance.
      run_lines(6, 858, 861);
      expect_lit(4, 32'd1, "jitter_unstable_set");
      run_lines(12, 858, 858);
      expect_lit(4, 32'd0,   "jitter_unstable_clear");
      expect_lit(0, 32'd858, "jitter_h_total");
      run_lines(10, 858, 860);
      expect_lit(4, 32'd0, "tol_unstable");

      // Missing HSYNC.
      repeat (4200) step(1'b0, 1'b0);
      expect_lit(4, 32'd1, "nohsync_unstable");

      // Reset in the middle of a field.
      run_field(10, 20, 7);
      reset = 1'b1;
      #1;
      expect_all_zero("midrst");
      repeat (3) @(posedge PCLK_in);
      #1;
      reset = 1'b0;
      mark = stb_count;
      run_lines(15, 20, 20);
      run_field(25, 20, 7);
      expect_lit(7, 32'(mark), "rst_first_vedge_no_stb");
      run_field(25, 20, 7);
      expect_lit(1, 32'd25,  "rst_vmax");
      expect_lit(2, 32'd500, "rst_pcnt_frame");
      expect_lit(7, 32'(mark + 1), "rst_stb_count");

      // Active-high syncs with coincident H and V edges.
      hsync_pol = 1'b0;
      vsync_pol = 1'b0;
      repeat (3) run_field(25, 20, 0);
      expect_lit(1, 32'd25,  "coinc_vmax");
      expect_lit(2, 32'd500, "coinc_pcnt_frame");
      expect_lit(0, 32'd20,  "coinc_h_total");
      expect_lit(3, 32'd0,   "coinc_ilace");

      repeat (2) @(negedge PCLK_in);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
